// File: rtl/ap_ctrl_drv_pkg.sv
// ap_ctrl_drv_pkg: shared state type and defaults for the ap_ctrl_hs kernel driver
package ap_ctrl_drv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int CNT_W_DEF = 32;
  localparam int DEPTH_DEF = 4;
  localparam logic [63:0] ALL_ONES = '1;
endpackage

// File: rtl/ap_ctrl_driver_if.sv
// ap_ctrl_driver_if: command and ap_ctrl_hs handshake bundle; master is the driver side
interface ap_ctrl_driver_if;
  logic cmd_valid;
  logic cmd_ready;
  logic [15:0] cmd_count;
  logic ap_start;
  logic ap_ready;
  logic ap_done;
  logic ap_continue;
  logic sink_ready;
  modport master (
    input cmd_valid, cmd_count, ap_ready, ap_done, sink_ready,
    output cmd_ready, ap_start, ap_continue
  );
  modport slave (
    output cmd_valid, cmd_count, ap_ready, ap_done, sink_ready,
    input cmd_ready, ap_start, ap_continue
  );
endinterface

// File: rtl/ap_ctrl_ts_fifo.sv
// ap_ctrl_ts_fifo: D x W start-timestamp FIFO with full/empty flags and simultaneous push/pop
module ap_ctrl_ts_fifo #(
  parameter int W = 32,
  parameter int D = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(D):0] level
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full = level == (AW+1)'(D);
  assign empty = level == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wr ? wp + 1'b1 : wp;
      rp <= rd ? rp + 1'b1 : rp;
      level <= level + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clock)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_driver: issues cmd_count ap_ctrl_hs invocations and gathers per-run latency statistics.
// Optional AP_CTRL_DRV_CONTINUE_EN drives ap_continue from sink_ready (tied high otherwise).
module ap_ctrl_driver
  import ap_ctrl_drv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic clock,
  input  logic reset,
  ap_ctrl_driver_if.master bus,
  output logic busy,
  output logic run_done,
  output logic [CNT_W-1:0] lat_min,
  output logic [CNT_W-1:0] lat_max,
  output logic [CNT_W-1:0] lat_total,
  output logic [15:0] done_cnt,
  output logic err_spurious
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] ONES = ALL_ONES[CNT_W-1:0];
  state_t st, st_n;
  logic [CNT_W-1:0] ts, start_ts, fifo_dout, lat;
  logic [CNT_W:0] sum;
  logic [15:0] issued, cnt, iss_n, cnt_n;
  logic [LW-1:0] level, lvl_n;
  logic empty, unused_full, held, held_n, ready_q, start_q, start_n;
  logic accept, hs, done_ok, pop;
  assign bus.cmd_ready = ready_q;
  assign bus.ap_start = start_q;
  assign accept = bus.cmd_valid && ready_q;
  assign hs = start_q && bus.ap_ready;
`ifdef AP_CTRL_DRV_CONTINUE_EN
  assign bus.ap_continue = bus.sink_ready || empty;
`else
  logic unused_sink;
  assign unused_sink = bus.sink_ready;
  assign bus.ap_continue = 1'b1;
`endif
  // a done held by the kernel while ap_continue is low is not a completion yet
  assign done_ok = bus.ap_done && bus.ap_continue;
  assign pop = done_ok && !empty;
  assign lat = ts - fifo_dout;
  assign sum = {1'b0, lat_total} + {1'b0, lat};
  ap_ctrl_ts_fifo #(.W(CNT_W), .D(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(hs),
    .pop(pop),
    .din(held ? start_ts : ts),
    .dout(fifo_dout),
    .full(unused_full),
    .empty(empty),
    .level(level)
  );
  always_comb begin
    cnt_n = accept ? bus.cmd_count : cnt;
    iss_n = accept ? '0 : issued + 16'(hs);
    lvl_n = level + LW'(hs) - LW'(pop);
    held_n = start_q && !bus.ap_ready;
    st_n = (st == IDLE) ? ((accept && bus.cmd_count != '0) ? RUN : IDLE)
         : (st == RUN) ? ((issued == cnt) ? DRAIN : RUN)
         : ((level == '0) ? IDLE : DRAIN);
    // a raised start is held until accepted; otherwise look at next-cycle issue/occupancy
    start_n = (st_n == RUN) && (held_n || (iss_n < cnt_n && lvl_n < LW'(DEPTH)));
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      st <= IDLE;
      ts <= '0;
      start_ts <= '0;
      issued <= '0;
      cnt <= '0;
      held <= 1'b0;
      start_q <= 1'b0;
      ready_q <= 1'b0;
      busy <= 1'b0;
      run_done <= 1'b0;
      err_spurious <= 1'b0;
      done_cnt <= '0;
      lat_min <= ONES;
      lat_max <= '0;
      lat_total <= '0;
    end else begin
      st <= st_n;
      ts <= ts + 1'b1;
      start_ts <= (start_q && !held) ? ts : start_ts;
      issued <= iss_n;
      cnt <= cnt_n;
      held <= held_n;
      start_q <= start_n;
      ready_q <= st_n == IDLE;
      busy <= st_n != IDLE;
      run_done <= (accept && bus.cmd_count == '0) || (st == DRAIN && st_n == IDLE);
      err_spurious <= err_spurious || (done_ok && empty);
      done_cnt <= accept ? '0 : done_cnt + 16'(pop);
      lat_min <= accept ? ONES : (pop && lat < lat_min) ? lat : lat_min;
      lat_max <= accept ? '0 : (pop && lat > lat_max) ? lat : lat_max;
      lat_total <= accept ? '0 : !pop ? lat_total : sum[CNT_W] ? ONES : sum[CNT_W-1:0];
    end
endmodule

// File: tb/tb_ap_ctrl_driver.sv
// tb_ap_ctrl_driver: directed bench driving ap_ctrl_driver through a small ap_ctrl_hs kernel model.
// Defining AP_CTRL_DRV_CONTINUE_EN switches the last scenario to sink_ready back-pressure.
module tb_ap_ctrl_driver;
  localparam int CW = 32;
  localparam longint ONES = 64'hFFFF_FFFF;
  logic clock = 1'b0;
  logic reset;
  logic busy, run_done, err_spurious;
  logic [CW-1:0] lat_min, lat_max, lat_total;
  logic [15:0] done_cnt;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int dly = 5;
  int rdy_wait = 0;
  int rdy_limit = 1 << 30;
  int stall = 0;
  int hs_total = 0;
  int peak = 0;
  int rd_pulses = 0;
  int rd0;
  bit spur = 1'b0;
  bit busy_seen = 1'b0;
  int due[$];

  ap_ctrl_driver_if bus();

  ap_ctrl_driver #(.CNT_W(CW), .DEPTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .run_done(run_done),
    .lat_min(lat_min),
    .lat_max(lat_max),
    .lat_total(lat_total),
    .done_cnt(done_cnt),
    .err_spurious(err_spurious)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // one clock: hand-off decided on pre-edge values, then kernel reacts to the new outputs
  task automatic step();
    bit took;
    #1;
    took = bus.ap_done && bus.ap_continue && due.size() > 0;
    @(posedge clock);
    #2;
    cyc++;
    if (took) void'(due.pop_front());
    rd_pulses += int'(run_done);
    busy_seen |= busy;
    bus.ap_ready = hs_total < rdy_limit && stall >= rdy_wait;
    if (bus.ap_start && bus.ap_ready) begin
      due.push_back(cyc + dly);
      hs_total++;
      stall = 0;
    end else if (bus.ap_start) stall++;
    peak = due.size() > peak ? due.size() : peak;
    bus.ap_done = spur || (due.size() > 0 && due[0] <= cyc);
  endtask

  task automatic run_cmd(input string tag, input int n);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_count = 16'(n);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 500) begin
      step();
      n++;
    end
    check({tag, "_idle_timeout"}, n < 500, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_count = '0;
    bus.ap_ready = 1'b0;
    bus.ap_done = 1'b0;
    bus.sink_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    check("rst_ap_start", bus.ap_start, 0);
    check("rst_busy", busy, 0);
    check("rst_run_done", run_done, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_err", err_spurious, 0);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_lat_total", lat_total, 0);
    check("rst_lat_max", lat_max, 0);
    check("rst_lat_min", lat_min, ONES);
    check("rst_ap_continue", bus.ap_continue, 1);
    reset = 1'b0;
    #1;
    check("rst_rel_cmd_ready_low", bus.cmd_ready, 0);
    step();
    check("rst_rel_cmd_ready_high", bus.cmd_ready, 1);

    // three pipelined invocations, kernel ready at once, done 5 cycles later
    rd0 = rd_pulses;
    run_cmd("s1", 3);
    check("s1_busy", busy, 1);
    wait_idle("s1");
    check("s1_done_cnt", done_cnt, 3);
    check("s1_lat_min", lat_min, 5);
    check("s1_lat_max", lat_max, 5);
    check("s1_lat_total", lat_total, 15);
    check("s1_run_done_pulses", rd_pulses - rd0, 1);

    // kernel takes the start 2 cycles late: latency counts from the first ap_start cycle
    rdy_wait = 2;
    dly = 4;
    run_cmd("s1b", 1);
    wait_idle("s1b");
    rdy_wait = 0;
    stall = 0;
    check("s1b_lat_min", lat_min, 6);
    check("s1b_lat_total", lat_total, 6);

    // FIFO back-pressure: at most 4 outstanding
    dly = 20;
    peak = 0;
    run_cmd("s2", 8);
    wait_idle("s2");
    check("s2_peak_outstanding", peak, 4);
    check("s2_done_cnt", done_cnt, 8);
    check("s2_lat_max", lat_max, 20);
    check("s2_lat_min", lat_min, 20);
    check("s2_lat_total", lat_total, 160);

    // zero-length run
    busy_seen = 1'b0;
    run_cmd("s3", 0);
    check("s3_run_done", run_done, 1);
    step();
    check("s3_run_done_once", run_done, 0);
    check("s3_lat_min", lat_min, ONES);
    check("s3_lat_max", lat_max, 0);
    check("s3_lat_total", lat_total, 0);
    check("s3_done_cnt", done_cnt, 0);
    check("s3_busy_seen", busy_seen, 0);

    // spurious done in IDLE
    check("s4_err_before", err_spurious, 0);
    spur = 1'b1;
    step();
    spur = 1'b0;
    step();
    check("s4_err_after", err_spurious, 1);
    check("s4_done_cnt", done_cnt, 0);

    // reset in RUN after 2 of 5 invocations
    dly = 1000;
    rdy_limit = hs_total + 2;
    rd0 = rd_pulses;
    run_cmd("s5", 5);
    n = 0;
    while (hs_total < rdy_limit && n < 100) begin
      step();
      n++;
    end
    check("s5_hs_timeout", n < 100, 1);
    step();
    check("s5_start_waiting", bus.ap_start, 1);
    reset = 1'b1;
    #1;
    check("s5_ap_start", bus.ap_start, 0);
    check("s5_busy", busy, 0);
    check("s5_done_cnt", done_cnt, 0);
    check("s5_err_cleared", err_spurious, 0);
    check("s5_cmd_ready", bus.cmd_ready, 0);
    due.delete();
    bus.ap_done = 1'b0;
    stall = 0;
    rdy_limit = 1 << 30;
    repeat (2) step();
    reset = 1'b0;
    step();
    check("s5_cmd_ready_back", bus.cmd_ready, 1);
    check("s5_no_run_done", rd_pulses - rd0, 0);

`ifdef AP_CTRL_DRV_CONTINUE_EN
    // kernel holds ap_done while sink_ready is low
    dly = 3;
    bus.sink_ready = 1'b0;
    run_cmd("s6", 1);
    repeat (3) step();
    check("s6_continue_low", bus.ap_continue, 0);
    repeat (10) step();
    check("s6_held_done_cnt", done_cnt, 0);
    bus.sink_ready = 1'b1;
    step();
    check("s6_released_done_cnt", done_cnt, 1);
    wait_idle("s6");
    check("s6_err", err_spurious, 0);
`else
    // ap_continue tied high: sink_ready has no effect
    dly = 3;
    bus.sink_ready = 1'b0;
    run_cmd("s6", 1);
    repeat (3) step();
    check("s6_continue_tied", bus.ap_continue, 1);
    wait_idle("s6");
    check("s6_done_cnt", done_cnt, 1);
    check("s6_lat_min", lat_min, 3);
    bus.sink_ready = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
